// File: rtl/req_arbiter_n.sv
// req_arbiter_n: N-way arbiter for one shared datapath resource.
// Arbitration is MSB-first, in either fixed-priority or round-robin mode.
// A winner keeps its grant until it drops its request or until MAX_HOLD
// grant cycles have elapsed. Each grant is followed by one RELEASE cycle and
// one IDLE cycle, so consecutive grants are always separated by two cycles
// with gnt == 0.
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous, active-high reset
//   req       in   N    request vector, bit i = requester i
//   rr_mode   in   1    0 = fixed MSB-first priority, 1 = round-robin
//                       (sampled only when arbitrating)
//   gnt       out  N    one-hot grant, all-zero when there is no owner
//   gnt_idx   out  IW   index of the current owner, 0 when gnt == 0
//   gnt_valid out  1    |gnt
//   preempt   out  1    one-cycle pulse: this release was forced by timeout
module req_arbiter_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 rr_mode,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 preempt
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic [IW-1:0]   r_gnt_idx;
    logic            r_gnt_valid;
    logic            r_preempt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [HW-1:0]   r_hold;

    logic [IW-1:0]   w_fix_idx;
    logic [IW-1:0]   w_rr_idx;
    logic [IW-1:0]   w_win;
    logic [N-1:0]    w_win_oh;

    // Winner selection. Both loops let the last matching assignment win:
    // the fixed loop walks upward so the highest set bit wins; the
    // round-robin loop walks the search order backwards (offset N down to 1)
    // so the first set bit at last-1, last-2, ... (wrapping) wins.
    always_comb begin
        w_fix_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                w_fix_idx = IW'(i);
            end
        end

        w_rr_idx = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            if (req[(32'(r_last) + N - k) % N]) begin
                w_rr_idx = IW'((32'(r_last) + N - k) % N);
            end
        end

        w_win    = rr_mode ? w_rr_idx : w_fix_idx;
        w_win_oh = '0;
        w_win_oh[w_win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_preempt   <= 1'b0;
            r_owner     <= '0;
            r_last      <= '0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_preempt <= 1'b0;
                    if (|req) begin
                        r_state     <= GRANT;
                        r_gnt       <= w_win_oh;
                        r_gnt_idx   <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_owner     <= w_win;
                        r_hold      <= '0;
                    end
                end

                GRANT: begin
                    // Saturating: the timeout releases before MAX_HOLD is reached.
                    if (r_hold != HW'(MAX_HOLD)) begin
                        r_hold <= r_hold + 1'b1;
                    end
                    // A request drop wins over a coincident timeout.
                    if (!req[r_owner]) begin
                        r_state     <= RELEASE;
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_preempt   <= 1'b0;
                    end else if (r_hold == HW'(MAX_HOLD - 1)) begin
                        r_state     <= RELEASE;
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_preempt   <= 1'b1;
                    end
                end

                RELEASE: begin
                    r_last    <= r_owner;
                    r_preempt <= 1'b0;
                    r_state   <= IDLE;
                end

                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= '0;
                    r_gnt_idx   <= '0;
                    r_gnt_valid <= 1'b0;
                    r_preempt   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_req_arbiter_n.sv
module tb_req_arbiter_n;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rr_mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who owns the resource, how many grant edges it
    // has been through, how many forced-idle edges remain before the next
    // arbitration, the previous owner, and the expected preempt pulse.
    int   m_owner;
    int   m_held;
    int   m_gap;
    int   m_last;
    logic m_pre;

    req_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input logic rr);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last - k + 2 * N) % N;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rr);
        int w;
        if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_pre   = r[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            w = pick(r, rr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        ei = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        chk({tag, ".gnt"},     32'(gnt),       32'(eg));
        chk({tag, ".idx"},     32'(gnt_idx),   32'(ei));
        chk({tag, ".valid"},   32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".preempt"}, 32'(preempt),   32'(m_pre));
    endtask

    // Called just after a rising edge; applies inputs, advances one edge,
    // then samples 1 time unit later.
    task automatic step(input string tag, input logic [3:0] r, input logic rr);
        req     = r;
        rr_mode = rr;
        @(posedge clk);
        model_edge(r, rr);
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".gnt0"},     32'(gnt),       32'd0);
        chk({tag, ".idx0"},     32'(gnt_idx),   32'd0);
        chk({tag, ".valid0"},   32'(gnt_valid), 32'd0);
        chk({tag, ".preempt0"}, 32'(preempt),   32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_zero(tag);
        #2 rst = 1'b0;
    endtask

    initial begin
        int order[$];
        logic prev_valid;
        logic [3:0] rq;
        logic rm;

        // Test 1: reset without any clock edge.
        rst = 1'b1; req = 4'b0; rr_mode = 1'b0;
        model_reset();
        #1;
        check_zero("t1_async");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step("t1_idle", 4'b0000, 1'b0);

        // Test 2: fixed mode, req=0110, requester 2 drops after 2 grant cycles.
        step("t2_g0", 4'b0110, 1'b0);
        chk("t2_first_gnt", 32'(gnt), 32'h4);
        chk("t2_first_idx", 32'(gnt_idx), 32'd2);
        step("t2_g1", 4'b0110, 1'b0);
        step("t2_rel", 4'b0010, 1'b0);
        step("t2_gap", 4'b0010, 1'b0);
        step("t2_g2", 4'b0010, 1'b0);
        chk("t2_second_gnt", 32'(gnt), 32'h2);
        chk("t2_second_idx", 32'(gnt_idx), 32'd1);
        for (int i = 0; i < 3; i++) step("t2_drain", 4'b0000, 1'b0);

        // Test 3: fixed mode, req=1000 held -> repeated timeouts.
        for (int i = 0; i < 14; i++) step("t3_hold", 4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) step("t3_drain", 4'b0000, 1'b0);

        // Test 4: round-robin from reset, all requesting.
        do_reset("t4_rst");
        prev_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step("t4_rr", 4'b1111, 1'b1);
            if (gnt_valid && !prev_valid) order.push_back(int'(gnt_idx));
            prev_valid = gnt_valid;
        end
        chk("t4_ngrants", 32'(order.size()), 32'd5);
        if (order.size() >= 5) begin
            chk("t4_order0", 32'(order[0]), 32'd3);
            chk("t4_order1", 32'(order[1]), 32'd2);
            chk("t4_order2", 32'(order[2]), 32'd1);
            chk("t4_order3", 32'(order[3]), 32'd0);
            chk("t4_order4", 32'(order[4]), 32'd3);
        end

        // Test 5: asynchronous reset in the middle of a grant.
        for (int i = 0; i < 3; i++) step("t5_drain", 4'b0000, 1'b0);
        step("t5_g", 4'b0100, 1'b0);
        step("t5_g", 4'b0100, 1'b0);
        chk("t5_gnt_before", 32'(gnt), 32'h4);
        do_reset("t5_rst");
        step("t5_rr", 4'b0001, 1'b1);
        chk("t5_rr_gnt", 32'(gnt), 32'h1);
        chk("t5_rr_idx", 32'(gnt_idx), 32'd0);

        // Test 6: rr_mode changes during a grant only affect the next arbitration.
        do_reset("t6_rst");
        step("t6_g", 4'b1111, 1'b0);
        chk("t6_fixed_idx", 32'(gnt_idx), 32'd3);
        step("t6_tog", 4'b1111, 1'b1);
        chk("t6_held_gnt", 32'(gnt), 32'h8);
        step("t6_tog", 4'b1111, 1'b1);
        step("t6_rel", 4'b0111, 1'b1);
        step("t6_gap", 4'b1011, 1'b1);
        step("t6_arb", 4'b1011, 1'b1);
        chk("t6_rr_idx", 32'(gnt_idx), 32'd1);

        // Randomised traffic against the reference model.
        rq = 4'($urandom);
        rm = 1'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            if ($urandom_range(0, 9) == 0) rm = ~rm;
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            step("rand", rq, rm);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
